sram22_rr_arbiter: RTL and testbench
====================================

Name: sram22_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one single-port SRAM22 macro (1024x32, 1-bit write mask, 1-cycle registered read).
- Each requester has a valid/ready request channel and a valid/ready read-response channel with a one-entry response buffer.
- Sits between the two client datapaths and the macro. Drives the macro's we/wmask/addr/din and captures dout.

Parameters:
- DATA_WIDTH, 32, word width; matches the macro.
- ADDR_WIDTH, 10, word address width; matches the macro.
- WMASK_WIDTH, 1, write-mask width; matches the macro.

Ports:
- clk  input  1  clock; also drives the SRAM clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  2  per-port request valid; bit p is port p.
- req_ready  output  2  per-port request accepted this cycle.
- req_we  input  2  per-port 1=write, 0=read.
- req_wmask  input  2*WMASK_WIDTH  per-port write mask; port p occupies slice [p*WMASK_WIDTH +: WMASK_WIDTH].
- req_addr  input  2*ADDR_WIDTH  per-port address, same slicing.
- req_din  input  2*DATA_WIDTH  per-port write data, same slicing.
- rsp_valid  output  2  per-port read data valid.
- rsp_ready  input  2  per-port read data consumed.
- rsp_data  output  2*DATA_WIDTH  per-port read data, same slicing.
- sram_we  output  1  to macro we.
- sram_wmask  output  WMASK_WIDTH  to macro wmask.
- sram_addr  output  ADDR_WIDTH  to macro addr.
- sram_din  output  DATA_WIDTH  to macro din.
- sram_dout  input  DATA_WIDTH  from macro dout.

Behaviour:
- Reset values (synchronous, active-high): rsp_valid=0, rsp_data=0, inflight[1:0]=0, last_grant=1 so port 0 wins the first contention.
  - Reset mid-operation discards any in-flight read and any buffered response.
- Eligibility of port p in cycle N:
  - A write request is always eligible.
  - A read request is eligible only if inflight[p]=0 and (rsp_valid[p]=0 or rsp_ready[p]=1).
- Arbitration (combinational in cycle N):
  - If only one port is eligible and valid, it wins.
  - If both are eligible and valid, the port != last_grant wins.
  - last_grant updates to the winner at the clock edge, only when a grant occurs.
  - An ineligible read never blocks the other port.
- Grant: req_ready[winner]=1 for exactly cycle N; a single grant per cycle. req_ready is 0 while rst=1.
- SRAM drive (combinational from the winner, sampled by the macro at the edge ending cycle N): sram_we, sram_wmask, sram_addr and sram_din come from the winner's request.
  - Idle cycle: sram_we=0, sram_wmask=0, sram_addr=0, sram_din=0.
  - An idle cycle is a harmless read of address 0 and is never returned to any port.
- Read pipeline:
  - Grant in cycle N sets inflight[p] at edge N and records the port.
  - sram_dout is valid in cycle N+1; at edge N+1, rsp_data[p] <= sram_dout, rsp_valid[p] <= 1, inflight[p] <= 0.
  - rsp_valid[p] first high in cycle N+2. Read latency is 2 cycles from grant to rsp_valid.
- Response handshake:
  - rsp_valid[p] and rsp_data[p] hold stable until the cycle with rsp_valid & rsp_ready; rsp_valid clears at that edge unless a new capture lands on the same edge, in which case the new data loads and valid stays 1.
  - Maximum read throughput per port is one read every 2 cycles. With both ports reading, the SRAM is busy every cycle.
- Writes: no response. The macro dout is X after a write; a write never captures dout.
- Read-after-write to the same address from either port, granted in later cycles, returns the new data.
- Simultaneous events:
  - Port 0 write with port 1 read: round-robin decides. The loser holds req_valid, and its req_ready stays 0.
  - rsp_ready asserted while rsp_valid=0 is ignored.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> rsp_valid=0, req_ready=0, sram_we=0, sram_addr=0; after release with no requests, outputs remain idle.
- Single-port write/read: port0 writes 0xDEADBEEF to addr 0x155 with wmask=1, then reads 0x155 with rsp_ready=1 -> req_ready high 1 cycle each; rsp_valid[0] high exactly 2 cycles after the read grant with rsp_data[0]=0xDEADBEEF.
- Round-robin contention: both ports hold continuous reads of addr 3 (port0) and 4 (port1), holding 0x3 and 0x4, with rsp_ready=1 -> grants alternate 0,1,0,1 starting with port0; the SRAM is busy every cycle; each port gets the correct data.
- Backpressure: port1 reads addr 7 (holding 0x77) with rsp_ready[1]=0 for 5 cycles, then issues a second read -> rsp_data[1] holds 0x77 stable; the second read is not granted until the rsp_ready[1]=1 cycle; port0 writes keep being granted meanwhile.
- Mask and write gap: port0 writes 0x12345678 to addr 9 with wmask=0, then reads addr 9 (previously 0) -> rsp_data[0]=0.
- Reset mid-read: grant a port0 read, assert rst in the next cycle -> rsp_valid[0] never asserts; after reset, port0 is granted first under contention.

Source files
------------

// File: rtl/sram22_rr_arbiter_if.sv
// Client-side request/response channels and SRAM22 macro pins for the
// two-port round-robin arbiter.
interface sram22_rr_arbiter_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WMASK_WIDTH = 1
);
  logic [1:0]               req_valid;
  logic [1:0]               req_ready;
  logic [1:0]               req_we;
  logic [2*WMASK_WIDTH-1:0] req_wmask;
  logic [2*ADDR_WIDTH-1:0]  req_addr;
  logic [2*DATA_WIDTH-1:0]  req_din;
  logic [1:0]               rsp_valid;
  logic [1:0]               rsp_ready;
  logic [2*DATA_WIDTH-1:0]  rsp_data;
  logic                     sram_we;
  logic [WMASK_WIDTH-1:0]   sram_wmask;
  logic [ADDR_WIDTH-1:0]    sram_addr;
  logic [DATA_WIDTH-1:0]    sram_din;
  logic [DATA_WIDTH-1:0]    sram_dout;

  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_din,
    input  rsp_ready, sram_dout,
    output req_ready, rsp_valid, rsp_data,
    output sram_we, sram_wmask, sram_addr, sram_din
  );

  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_din,
    output rsp_ready, sram_dout,
    input  req_ready, rsp_valid, rsp_data,
    input  sram_we, sram_wmask, sram_addr, sram_din
  );
endinterface

// File: rtl/sram22_rr_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM22 macro.
// Reads return two cycles after grant through a one-entry buffer per port.
module sram22_rr_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WMASK_WIDTH = 1
) (
  input logic                clk,
  input logic                rst,
  sram22_rr_arbiter_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int MW = WMASK_WIDTH;

  logic            last_q, last_d;
  logic [1:0]      infl_q, infl_d;
  logic [1:0]      vld_q, vld_d;
  logic [2*DW-1:0] data_q, data_d;

  logic [1:0] rd_ok;
  logic [1:0] elig;
  logic [1:0] gnt;
  logic       win;

  // A read may issue only when its buffer is free or drains this cycle.
  assign rd_ok = ~infl_q & (~vld_q | bus.rsp_ready);
  assign elig  = {2{~rst}} & bus.req_valid & (bus.req_we | rd_ok);

  always_comb begin
    win = elig[1];
    if (&elig) win = ~last_q;
    gnt = 2'b00;
    if (|elig) gnt = win ? 2'b10 : 2'b01;
  end

  // Idle cycles present a harmless read of address 0.
  always_comb begin
    bus.sram_we    = 1'b0;
    bus.sram_wmask = '0;
    bus.sram_addr  = '0;
    bus.sram_din   = '0;
    if (|gnt) begin
      bus.sram_we    = bus.req_we[win];
      bus.sram_wmask = win ? bus.req_wmask[MW +: MW]
                           : bus.req_wmask[0 +: MW];
      bus.sram_addr  = win ? bus.req_addr[AW +: AW]
                           : bus.req_addr[0 +: AW];
      bus.sram_din   = win ? bus.req_din[DW +: DW]
                           : bus.req_din[0 +: DW];
    end
  end

  always_comb begin
    last_d = last_q;
    if (|gnt) last_d = win;
    infl_d = gnt & ~bus.req_we;
    vld_d  = (vld_q & ~bus.rsp_ready) | infl_q;
    data_d = data_q;
    if (infl_q[0]) data_d[0 +: DW]  = bus.sram_dout;
    if (infl_q[1]) data_d[DW +: DW] = bus.sram_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
      infl_q <= '0;
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      last_q <= last_d;
      infl_q <= infl_d;
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_data  = data_q;
endmodule

// File: tb/tb_sram22_rr_arbiter.sv
// Bench for sram22_rr_arbiter: SRAM macro model, queue-based reference
// scoreboard, directed scenarios and a randomized run.
module tb_sram22_rr_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   mem_clr = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sram22_rr_arbiter_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)
  ) bus ();

  sram22_rr_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Macro: 1-cycle registered read, dout garbage after a write.
  logic [DW-1:0] mem_s [1024];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem_s[i] <= '0;
    end else if (bus.sram_we) begin
      if (bus.sram_wmask[0]) mem_s[bus.sram_addr] <= bus.sram_din;
      bus.sram_dout <= $urandom;
    end else begin
      bus.sram_dout <= mem_s[bus.sram_addr];
    end
  end

  // Reference: expected responses are queued with their due cycle.
  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } ent_t;

  ent_t          q0[$];
  ent_t          q1[$];
  logic [DW-1:0] mem_r [1024];
  bit            last_m = 1'b1;
  int            cyc = 0;

  initial for (int i = 0; i < 1024; i++) mem_r[i] = '0;

  function automatic bit hv(input int p);
    if (p == 0) return q0.size() > 0 && q0[0].due <= cyc;
    return q1.size() > 0 && q1[0].due <= cyc;
  endfunction

  function automatic bit busy(input int p);
    if (p == 0) return q0.size() > 0 && q0[q0.size()-1].due > cyc;
    return q1.size() > 0 && q1[q1.size()-1].due > cyc;
  endfunction

  function automatic logic [DW-1:0] hd(input int p);
    if (p == 0) return (q0.size() > 0) ? q0[0].d : '0;
    return (q1.size() > 0) ? q1[0].d : '0;
  endfunction

  logic [1:0]    m_ev, m_el, m_eg;
  bit            m_w;
  logic          x_we;
  logic [MW-1:0] x_mask;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_din;
  ent_t          m_e;

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      m_ev[p] = hv(p);
      n_chk += 1;
      if (bus.rsp_valid[p] !== m_ev[p]) begin
        n_fail += 1;
        $display("FAIL mon_rsp_valid%0d cyc %0d got %b exp %b",
                 p, cyc, bus.rsp_valid[p], m_ev[p]);
      end
      if (m_ev[p]) begin
        n_chk += 1;
        if (bus.rsp_data[p*DW +: DW] !== hd(p)) begin
          n_fail += 1;
          $display("FAIL mon_rsp_data%0d cyc %0d got %h exp %h",
                   p, cyc, bus.rsp_data[p*DW +: DW], hd(p));
        end
      end
    end
    m_el = 2'b00;
    if (!rst)
      for (int p = 0; p < 2; p++)
        m_el[p] = bus.req_valid[p] &&
                  (bus.req_we[p] ||
                   (!busy(p) && (!m_ev[p] || bus.rsp_ready[p])));
    m_w = (m_el == 2'b11) ? !last_m : m_el[1];
    m_eg = (m_el != 2'b00) ? (m_w ? 2'b10 : 2'b01) : 2'b00;
    x_we = 1'b0;
    x_mask = '0;
    x_addr = '0;
    x_din = '0;
    if (m_el != 2'b00) begin
      x_we   = bus.req_we[m_w];
      x_mask = bus.req_wmask[m_w*MW +: MW];
      x_addr = bus.req_addr[m_w*AW +: AW];
      x_din  = bus.req_din[m_w*DW +: DW];
    end
    n_chk += 1;
    if (bus.req_ready !== m_eg) begin
      n_fail += 1;
      $display("FAIL mon_req_ready cyc %0d got %b exp %b",
               cyc, bus.req_ready, m_eg);
    end
    n_chk += 1;
    if ({bus.sram_we, bus.sram_wmask, bus.sram_addr, bus.sram_din}
        !== {x_we, x_mask, x_addr, x_din}) begin
      n_fail += 1;
      $display("FAIL mon_sram cyc %0d got %b/%b/%h/%h exp %b/%b/%h/%h",
               cyc, bus.sram_we, bus.sram_wmask, bus.sram_addr,
               bus.sram_din, x_we, x_mask, x_addr, x_din);
    end
    if (rst) begin
      q0.delete();
      q1.delete();
      last_m = 1'b1;
    end else begin
      if (m_ev[0] && bus.rsp_ready[0]) q0.delete(0);
      if (m_ev[1] && bus.rsp_ready[1]) q1.delete(0);
      if (m_el != 2'b00) begin
        last_m = m_w;
        if (x_we) begin
          if (x_mask[0]) mem_r[x_addr] = x_din;
        end else begin
          m_e.d = mem_r[x_addr];
          m_e.due = cyc + 2;
          if (m_w) q1.push_back(m_e);
          else q0.push_back(m_e);
        end
      end
    end
    cyc += 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req_valid = 2'b00;
    bus.req_we    = 2'b00;
    bus.req_wmask = '0;
    bus.req_addr  = '0;
    bus.req_din   = '0;
  endtask

  task automatic set_req(input int p, input bit we, input bit m,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_valid[p]         = 1'b1;
    bus.req_we[p]            = we;
    bus.req_wmask[p*MW +: MW] = m;
    bus.req_addr[p*AW +: AW] = a;
    bus.req_din[p*DW +: DW]  = d;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a,
                    input logic [DW-1:0] d);
    idle();
    set_req(p, 1'b1, 1'b1, a, d);
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.rsp_ready = 2'b00;
    idle();
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk += 1;
      if ({bus.req_ready, bus.rsp_valid, bus.sram_we, bus.sram_addr}
          !== '0) begin
        n_fail += 1;
        $display("FAIL reset_outputs got rr=%b rv=%b we=%b a=%h exp 0",
                 bus.req_ready, bus.rsp_valid, bus.sram_we, bus.sram_addr);
      end
      n_chk += 1;
      if (bus.rsp_data !== '0) begin
        n_fail += 1;
        $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data);
      end
      tick();
      mem_clr = 1'b0;
    end
    rst = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk += 1;
      if ({bus.req_ready, bus.rsp_valid, bus.sram_we, bus.sram_addr}
          !== '0) begin
        n_fail += 1;
        $display("FAIL idle_outputs got rr=%b rv=%b we=%b a=%h exp 0",
                 bus.req_ready, bus.rsp_valid, bus.sram_we, bus.sram_addr);
      end
      tick();
    end
  endtask

  task automatic test_single();
    bus.rsp_ready = 2'b11;
    idle();
    set_req(0, 1'b1, 1'b1, 10'h155, 32'hDEADBEEF);
    @(negedge clk);
    n_chk += 1;
    if (bus.req_ready !== 2'b01) begin
      n_fail += 1;
      $display("FAIL single_wr_grant got %b exp 01", bus.req_ready);
    end
    tick();
    idle();
    set_req(0, 1'b0, 1'b0, 10'h155, '0);
    @(negedge clk);
    n_chk += 1;
    if (bus.req_ready !== 2'b01) begin
      n_fail += 1;
      $display("FAIL single_rd_grant got %b exp 01", bus.req_ready);
    end
    tick();
    idle();
    @(negedge clk);
    n_chk += 1;
    if (bus.rsp_valid[0] !== 1'b0) begin
      n_fail += 1;
      $display("FAIL single_early_valid got %b exp 0", bus.rsp_valid[0]);
    end
    tick();
    @(negedge clk);
    n_chk += 1;
    if (bus.rsp_valid[0] !== 1'b1 ||
        bus.rsp_data[0 +: DW] !== 32'hDEADBEEF) begin
      n_fail += 1;
      $display("FAIL single_rsp got v=%b d=%h exp 1/deadbeef",
               bus.rsp_valid[0], bus.rsp_data[0 +: DW]);
    end
    tick();
    @(negedge clk);
    n_chk += 1;
    if (bus.rsp_valid[0] !== 1'b0) begin
      n_fail += 1;
      $display("FAIL single_consume got %b exp 0", bus.rsp_valid[0]);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    bus.rsp_ready = 2'b11;
    wr(0, 10'd3, 32'h3);
    wr(1, 10'd4, 32'h4);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      set_req(0, 1'b0, 1'b0, 10'd3, '0);
      set_req(1, 1'b0, 1'b0, 10'd4, '0);
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      n_chk += 1;
      if (bus.req_ready !== eg ||
          bus.sram_addr !== ((i % 2 == 0) ? 10'd3 : 10'd4)) begin
        n_fail += 1;
        $display("FAIL rr_grant i=%0d got %b/%h exp %b", i,
                 bus.req_ready, bus.sram_addr, eg);
      end
      if (i >= 2) begin
        n_chk += 1;
        if (bus.rsp_valid !== eg ||
            bus.rsp_data[((i % 2 == 0) ? 0 : DW) +: DW] !==
            ((i % 2 == 0) ? 32'h3 : 32'h4)) begin
          n_fail += 1;
          $display("FAIL rr_rsp i=%0d got v=%b d=%h exp v=%b", i,
                   bus.rsp_valid, bus.rsp_data, eg);
        end
      end
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 2'b11;
    wr(1, 10'd7, 32'h77);
    wr(1, 10'd8, 32'h88);
    bus.rsp_ready = 2'b01;
    set_req(1, 1'b0, 1'b0, 10'd7, '0);
    @(negedge clk);
    n_chk += 1;
    if (bus.req_ready !== 2'b10) begin
      n_fail += 1;
      $display("FAIL bp_first_grant got %b exp 10", bus.req_ready);
    end
    tick();
    idle();
    set_req(0, 1'b1, 1'b1, 10'd20, $urandom);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_req(0, 1'b1, 1'b1, 10'(21 + k), $urandom);
      set_req(1, 1'b0, 1'b0, 10'd8, '0);
      @(negedge clk);
      n_chk += 1;
      if (bus.req_ready !== 2'b01 || bus.rsp_valid[1] !== 1'b1 ||
          bus.rsp_data[DW +: DW] !== 32'h77) begin
        n_fail += 1;
        $display("FAIL bp_hold k=%0d got rr=%b v=%b d=%h exp 01/1/77",
                 k, bus.req_ready, bus.rsp_valid[1],
                 bus.rsp_data[DW +: DW]);
      end
      tick();
    end
    bus.rsp_ready = 2'b11;
    set_req(0, 1'b1, 1'b1, 10'd30, $urandom);
    @(negedge clk);
    n_chk += 1;
    if (bus.req_ready !== 2'b10) begin
      n_fail += 1;
      $display("FAIL bp_release got %b exp 10", bus.req_ready);
    end
    tick();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_mask();
    bus.rsp_ready = 2'b11;
    wr(0, 10'd9, 32'h0);
    set_req(0, 1'b1, 1'b0, 10'd9, 32'h12345678);
    @(negedge clk);
    n_chk += 1;
    if (bus.req_ready !== 2'b01 || bus.sram_wmask !== 1'b0 ||
        bus.sram_din !== 32'h12345678) begin
      n_fail += 1;
      $display("FAIL mask_wr got rr=%b m=%b d=%h exp 01/0/12345678",
               bus.req_ready, bus.sram_wmask, bus.sram_din);
    end
    tick();
    idle();
    set_req(0, 1'b0, 1'b0, 10'd9, '0);
    tick();
    idle();
    tick();
    @(negedge clk);
    n_chk += 1;
    if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_data[0 +: DW] !== '0) begin
      n_fail += 1;
      $display("FAIL mask_rd got v=%b d=%h exp 1/0",
               bus.rsp_valid[0], bus.rsp_data[0 +: DW]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 2'b11;
    idle();
    set_req(0, 1'b0, 1'b0, 10'd3, '0);
    tick();
    rst = 1'b1;
    set_req(1, 1'b0, 1'b0, 10'd4, '0);
    @(negedge clk);
    n_chk += 1;
    if (bus.req_ready !== 2'b00 || bus.sram_we !== 1'b0) begin
      n_fail += 1;
      $display("FAIL rstmid_ready got %b exp 00", bus.req_ready);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk += 1;
      if (bus.rsp_valid !== 2'b00 ||
          bus.req_ready !== ((k == 0) ? 2'b01 : 2'b10)) begin
        n_fail += 1;
        $display("FAIL rstmid_after k=%0d got v=%b rr=%b", k,
                 bus.rsp_valid, bus.req_ready);
      end
      tick();
    end
    idle();
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      idle();
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 3) != 0)
          set_req(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  10'($urandom_range(0, 15)), $urandom);
      bus.rsp_ready = {1'($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 3) != 0)};
      @(negedge clk);
      n_chk += 1;
      if (!$onehot0(bus.req_ready) ||
          (bus.req_ready & ~bus.req_valid) != 2'b00) begin
        n_fail += 1;
        $display("FAIL rand_grant i=%0d got %b valid %b", i,
                 bus.req_ready, bus.req_valid);
      end
      tick();
    end
    rst = 1'b0;
    idle();
    bus.rsp_ready = 2'b11;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    idle();
    bus.rsp_ready = 2'b00;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
